tl_cntr_n: RTL and testbench

- Parametrised N-road traffic-light controller; successor to the two-road Ta/Tb, La/Lb controller.
- Serves one road at a time in round-robin order, driven by per-road vehicle sensors.
- Each switch-over runs a green phase with minimum and maximum green time, then a yellow phase, then an all-red clearance phase.
- Sits between the synchronised sensor inputs and the lamp drivers of an intersection.

---
 rtl/tl_pkg.sv | 25 ++
 rtl/tl_rr_pick.sv | 39 +++
 rtl/tl_cntr_n.sv | 154 +++++++++++++++
 tb/tb_tl_cntr_n.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared encodings for the N-road traffic-light controller.
// Lamp codes drive the per-road lamp fields; phase codes are exposed on the
// controller's phase output so downstream logic can tell where it is in a
// switch-over.
package tl_pkg;

    // Width of one road's lamp field inside the packed lights bus.
    localparam int LAMP_W = 2;

    // Lamp drive codes for a single approach.
    typedef enum logic [LAMP_W-1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } lamp_t;

    // Switch-over phases. Code 2'b11 is never produced and is steered back
    // to all-red, which is the safe state for the intersection.
    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_t;

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin search.
// Scans req starting at index 'start' and wrapping from N_ROAD-1 back to 0;
// the first set bit found is returned on 'grant' with 'valid' high. When no
// bit is set, valid is low and grant is 0.
//
// Ports:
//   req   - request vector, one bit per road
//   start - first index to examine
//   grant - index of the first requesting road at or after start
//   valid - at least one request was found
module tl_rr_pick #(
    parameter int N_ROAD = 4,
    parameter int AW     = 2
) (
    input  logic [N_ROAD-1:0] req,
    input  logic [AW-1:0]     start,
    output logic [AW-1:0]     grant,
    output logic              valid
);

    // Walk the ring once, carrying the probe index with an explicit wrap so
    // no modulo hardware is needed for non-power-of-two road counts. The
    // first hit wins; later hits are ignored once valid is set.
    logic [AW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = start;
        for (int j = 0; j < N_ROAD; j++) begin
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
            idx = (idx == AW'(N_ROAD - 1)) ? '0 : idx + AW'(1);
        end
    end

endmodule

// File: rtl/tl_cntr_n.sv
// N-road traffic-light controller.
// One road owns the intersection at a time. A switch-over runs green (with a
// minimum and, when others wait, a maximum length), then yellow, then an
// all-red clearance, after which the next requesting road in round-robin
// order receives green. With nobody else waiting, green is held indefinitely.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset
//   sensor - vehicle present per road, already synchronous to clk
//   lights - lamp code for road i on bits [2i+1:2i]
//   active - road currently owning green, yellow or all-red
//   phase  - current phase code (PH_GREEN / PH_YELLOW / PH_ALLRED)
module tl_cntr_n
    import tl_pkg::*;
#(
    parameter int N_ROAD    = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 16,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    localparam int AW       = (N_ROAD > 2) ? $clog2(N_ROAD) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_ROAD-1:0]          sensor,
    output logic [LAMP_W*N_ROAD-1:0]   lights,
    output logic [AW-1:0]              active,
    output logic [1:0]                 phase
);

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);

    phase_t                     phase_q, phase_d;
    logic [AW-1:0]              active_q, active_d;
    logic [AW-1:0]              next_q, next_d;
    logic [CNT_W-1:0]           timer_q, timer_d;
    logic [LAMP_W*N_ROAD-1:0]   lights_q, lights_d;

    logic [N_ROAD-1:0]          req_masked;
    logic [AW-1:0]              start_idx;
    logic [AW-1:0]              pick_grant;
    logic                       pick_valid;
    logic                       other_req;
    logic                       own_req;

    // Lamp pattern for a given phase/owner: only the owner can be non-red,
    // and even the owner is red during all-red or an unknown phase code.
    function automatic logic [LAMP_W*N_ROAD-1:0] lamp_decode(input phase_t ph,
                                                             input logic [AW-1:0] act);
        logic [LAMP_W*N_ROAD-1:0] v;
        v = '0;
        for (int i = 0; i < N_ROAD; i++) begin
            v[LAMP_W*i +: LAMP_W] = RED;
            if (AW'(i) == act) begin
                case (ph)
                    PH_GREEN:  v[LAMP_W*i +: LAMP_W] = GREEN;
                    PH_YELLOW: v[LAMP_W*i +: LAMP_W] = YELLOW;
                    default:   v[LAMP_W*i +: LAMP_W] = RED;
                endcase
            end
        end
        return v;
    endfunction

    // The search begins just past the current owner, and the owner's own
    // request is hidden so it can never be re-chosen as its own successor.
    assign start_idx  = (active_q == AW'(N_ROAD - 1)) ? '0 : active_q + AW'(1);
    assign req_masked = sensor & ~(N_ROAD'(1) << active_q);
    assign other_req  = |req_masked;
    assign own_req    = sensor[active_q];

    tl_rr_pick #(
        .N_ROAD (N_ROAD),
        .AW     (AW)
    ) u_pick (
        .req    (req_masked),
        .start  (start_idx),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    // State register. Lights are registered alongside phase/active so the
    // lamp drivers see a glitch-free bus that changes in the same cycle as
    // the phase code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_GREEN;
            active_q <= '0;
            next_q   <= '0;
            timer_q  <= '0;
            lights_q <= lamp_decode(PH_GREEN, '0);
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            next_q   <= next_d;
            timer_q  <= timer_d;
            lights_q <= lights_d;
        end
    end

    // Next-state logic. The timer counts cycles spent in the current phase
    // and restarts at 0 on every phase entry. Green leaves once the minimum
    // has elapsed and someone else is waiting, either because the owner has
    // gone quiet or because the maximum has been reached; the successor is
    // latched at that moment so later sensor changes cannot redirect it.
    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        next_d   = next_q;
        timer_d  = timer_q + CNT_W'(1);
        case (phase_q)
            PH_GREEN: begin
                if ((timer_q >= GMIN_M1) && other_req &&
                    (!own_req || (timer_q >= GMAX_M1))) begin
                    phase_d = PH_YELLOW;
                    timer_d = '0;
                    if (pick_valid) begin
                        next_d = pick_grant;
                    end
                end else if (timer_q >= GMAX_M1) begin
                    timer_d = GMAX_M1;
                end
            end
            PH_YELLOW: begin
                if (timer_q >= YEL_M1) begin
                    phase_d = PH_ALLRED;
                    timer_d = '0;
                end
            end
            PH_ALLRED: begin
                if (timer_q >= AR_M1) begin
                    phase_d  = PH_GREEN;
                    active_d = next_q;
                    timer_d  = '0;
                end
            end
            default: begin
                phase_d = PH_ALLRED;
                timer_d = '0;
            end
        endcase
        lights_d = lamp_decode(phase_d, active_d);
    end

    assign lights = lights_q;
    assign active = active_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_tl_cntr_n.sv
// Self-checking bench for tl_cntr_n with default parameters.
// A behavioural model tracks phase, owner, latched successor and the number
// of cycles spent in the current phase, and predicts the packed
// {lights, phase, active} vector after every clock edge. Directed scenarios
// add fixed expectations at the cycles where the intersection must switch.
module tb_tl_cntr_n;

    localparam int N         = 4;
    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 16;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;

    logic         clk;
    logic         reset;
    logic [N-1:0] sensor;
    logic [7:0]   lights;
    logic [1:0]   active;
    logic [1:0]   phase;

    int n_cmp;
    int n_fail;

    // Model state: phase code, owner, chosen successor, cycles in phase.
    int m_phase;
    int m_active;
    int m_next;
    int m_elapsed;

    tl_cntr_n dut (
        .clk    (clk),
        .reset  (reset),
        .sensor (sensor),
        .lights (lights),
        .active (active),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First requesting road after 'act' going round the ring, never 'act'.
    function automatic int rr_next(input logic [N-1:0] s, input int act);
        for (int d = 1; d < N; d++) begin
            if (s[2'((act + d) % N)]) return (act + d) % N;
        end
        return act;
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [7:0] v;
        for (int i = 0; i < N; i++) begin
            if (i != m_active || m_phase == 2) v[2*i +: 2] = 2'b10;
            else if (m_phase == 0)             v[2*i +: 2] = 2'b00;
            else                               v[2*i +: 2] = 2'b01;
        end
        return {v, 2'(m_phase), 2'(m_active)};
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_active  = 0;
        m_next    = 0;
        m_elapsed = 0;
    endtask

    // Advance the model by one clock using the sensor value seen at the edge.
    task automatic model_step();
        int own;
        int others;
        own    = sensor[2'(m_active)] ? 1 : 0;
        others = 0;
        for (int j = 0; j < N; j++) begin
            if (j != m_active && sensor[2'(j)]) others = 1;
        end
        case (m_phase)
            0: begin
                if (m_elapsed + 1 >= GREEN_MIN && others == 1 &&
                    (own == 0 || m_elapsed + 1 >= GREEN_MAX)) begin
                    m_next    = rr_next(sensor, m_active);
                    m_phase   = 1;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
            1: begin
                if (m_elapsed + 1 >= YELLOW_T) begin
                    m_phase   = 2;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
            default: begin
                if (m_elapsed + 1 >= ALLRED_T) begin
                    m_phase   = 0;
                    m_active  = m_next;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
        endcase
    endtask

    // One clock: model follows the edge, then the bench settles on negedge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        sensor = '0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset  = 1'b1;
        sensor = '0;
        #1;
        n_cmp++;
        if ({lights, phase, active} !== 12'b10101000_00_00) begin
            n_fail++;
            $display("[TB] FAIL reset_assert: got %b exp %b", {lights, phase, active}, 12'b10101000_00_00);
        end
        tick();
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 50; k++) begin
            n_cmp++;
            if ({lights, phase, active} !== 12'b10101000_00_00) begin
                n_fail++;
                $display("[TB] FAIL reset_idle k=%0d: got %b exp %b", k, {lights, phase, active}, 12'b10101000_00_00);
            end
            tick();
        end
    endtask

    task automatic test_single_request();
        do_reset();
        sensor = 4'b0100;
        for (int k = 0; k < 14; k++) begin
            n_cmp++;
            if ({lights, phase, active} !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL single_req k=%0d: got %b exp %b", k, {lights, phase, active}, exp_vec());
            end
            if (k == 4 || k == 6 || k == 7) begin
                n_cmp++;
                if ((k == 4 && lights !== 8'b10101001) || (k == 6 && lights !== 8'b10101010) ||
                    (k == 7 && {phase, active} !== 4'b0010)) begin
                    n_fail++;
                    $display("[TB] FAIL single_req_fixed k=%0d: got lights=%b phase=%0d active=%0d", k, lights, phase, active);
                end
            end
            tick();
        end
    endtask

    task automatic test_max_green();
        do_reset();
        sensor = 4'b0011;
        for (int k = 0; k < 26; k++) begin
            n_cmp++;
            if ({lights, phase, active} !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL max_green k=%0d: got %b exp %b", k, {lights, phase, active}, exp_vec());
            end
            if (k == 15 || k == 16 || k == 19) begin
                n_cmp++;
                if ((k == 15 && {phase, active} !== 4'b0000) || (k == 16 && {phase, active} !== 4'b0100) ||
                    (k == 19 && {phase, active} !== 4'b0001)) begin
                    n_fail++;
                    $display("[TB] FAIL max_green_fixed k=%0d: got phase=%0d active=%0d", k, phase, active);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sensor = 4'b1111;
        for (int k = 0; k < 80; k++) begin
            n_cmp++;
            if ({lights, phase, active} !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL back_to_back k=%0d: got %b exp %b", k, {lights, phase, active}, exp_vec());
            end
            if (k % 19 == 0) begin
                n_cmp++;
                if (phase !== 2'd0 || active !== 2'((k / 19) % 4)) begin
                    n_fail++;
                    $display("[TB] FAIL back_to_back_order k=%0d: got phase=%0d active=%0d exp phase=0 active=%0d", k, phase, active, (k / 19) % 4);
                end
            end
            if (k % 19 == 16) begin
                n_cmp++;
                if (phase !== 2'd1) begin
                    n_fail++;
                    $display("[TB] FAIL back_to_back_len k=%0d: got phase=%0d exp 1", k, phase);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap_and_drop();
        do_reset();
        sensor = 4'b0100;
        for (int k = 0; k < 22; k++) begin
            n_cmp++;
            if ({lights, phase, active} !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL wrap k=%0d: got %b exp %b", k, {lights, phase, active}, exp_vec());
            end
            if (k == 14) begin
                n_cmp++;
                if ({phase, active} !== 4'b0000) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_fixed k=%0d: got phase=%0d active=%0d exp 0/0", k, phase, active);
                end
            end
            if (k == 7) sensor = 4'b0001;
            tick();
        end
        do_reset();
        sensor = 4'b1000;
        for (int k = 0; k < 22; k++) begin
            n_cmp++;
            if ({lights, phase, active} !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL drop k=%0d: got %b exp %b", k, {lights, phase, active}, exp_vec());
            end
            if (k == 7 || k == 20) begin
                n_cmp++;
                if ({phase, active} !== 4'b0011) begin
                    n_fail++;
                    $display("[TB] FAIL drop_fixed k=%0d: got phase=%0d active=%0d exp 0/3", k, phase, active);
                end
            end
            if (k == 4) sensor = 4'b0000;
            tick();
        end
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        sensor = 4'b0010;
        for (int k = 0; k < 11; k++) begin
            if (k == 7) sensor = 4'b0001;
            tick();
        end
        n_cmp++;
        if ({phase, active} !== 4'b0101 || {lights, phase, active} !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_yellow: got %b exp %b", {lights, phase, active}, exp_vec());
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({lights, phase, active} !== 12'b10101000_00_00) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_yellow: got %b exp %b", {lights, phase, active}, 12'b10101000_00_00);
        end
        tick();
        reset = 1'b0;
        model_reset();
        sensor = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if ({lights, phase, active} !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL after_reset k=%0d: got %b exp %b", k, {lights, phase, active}, exp_vec());
            end
            if (k == 7) begin
                n_cmp++;
                if ({phase, active} !== 4'b0010) begin
                    n_fail++;
                    $display("[TB] FAIL after_reset_fixed k=%0d: got phase=%0d active=%0d exp 0/2", k, phase, active);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            n_cmp++;
            if ({lights, phase, active} !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random k=%0d sensor=%b: got %b exp %b", k, sensor, {lights, phase, active}, exp_vec());
            end
            if ($urandom_range(0, 7) == 0) sensor = 4'($urandom_range(0, 15));
            tick();
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        sensor = '0;
        model_reset();
        test_reset();
        test_single_request();
        test_max_green();
        test_back_to_back();
        test_wrap_and_drop();
        test_reset_mid_phase();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
